uart_rx_paddle: RTL and testbench

//  Receive side of the inter-board PONG link: deserialises the 8N1 UART stream sent by the

---
 rtl/pong_uart_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 115 +++++++++++
 rtl/uart_rx_paddle.sv | 88 ++++++++
 tb/tb_uart_rx_paddle.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pong_uart_pkg.sv
// Shared constants and receiver state type for the PONG board-to-board UART link.
// Used by both the receive path and the button transmitter.
package pong_uart_pkg;

    localparam int CLK_FREQ  = 65_000_000;
    localparam int BAUD_RATE = 9_600;
    localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC  = BIT_CYC / 2;

    localparam logic [7:0] CMD_UP   = 8'h41;
    localparam logic [7:0] CMD_DOWN = 8'h42;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, one-cycle valid/error pulses.
// rx_valid/frame_err rise 1 clk after the mid-stop-bit sample; no backpressure, bytes are dropped if unread.
module uart_rx_core
    import pong_uart_pkg::*;
#(
    parameter int CYC_PER_BIT  = BIT_CYC,
    parameter int CYC_HALF_BIT = HALF_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int BAUD_W = (CYC_PER_BIT > 2) ? $clog2(CYC_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CYC_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CYC_HALF_BIT - 1);

    logic [1:0]        sync_q;
    logic              rxd_s;
    uart_rx_state_t    state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], RxD};
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                // Re-check at mid start bit so short glitches fall back to IDLE.
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_q == 4'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        data_d = shift_q;
                        vld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = vld_q;
    assign frame_err = err_q;

endmodule

// File: rtl/uart_rx_paddle.sv
// Remote paddle control: decodes 'A'/'B' command bytes into level-held up/down for HOLD_CYCLES.
// remote_* change 1 clk after rx_valid; no backpressure, every received command takes effect.
module uart_rx_paddle #(
    parameter int CLK_FREQ    = pong_uart_pkg::CLK_FREQ,
    parameter int BAUD_RATE   = pong_uart_pkg::BAUD_RATE,
    parameter int HOLD_CYCLES = 150_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       remote_up,
    output logic       remote_down
);

    import pong_uart_pkg::CMD_UP;
    import pong_uart_pkg::CMD_DOWN;

    localparam int BIT_CYC_L  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC_L = BIT_CYC_L / 2;
    localparam int HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    logic [7:0]        core_data;
    logic              core_vld;
    logic              core_err;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              up_q, up_d;
    logic              down_q, down_d;

    uart_rx_core #(
        .CYC_PER_BIT  (BIT_CYC_L),
        .CYC_HALF_BIT (HALF_CYC_L)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .RxD       (RxD),
        .rx_data   (core_data),
        .rx_valid  (core_vld),
        .frame_err (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    always_comb begin
        hold_d = hold_q;
        up_d   = up_q;
        down_d = down_q;
        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) begin
                up_d   = 1'b0;
                down_d = 1'b0;
            end
        end
        // A fresh command wins over expiry and always clears the opposite direction.
        if (core_vld) begin
            if (core_data == CMD_UP) begin
                up_d   = 1'b1;
                down_d = 1'b0;
                hold_d = HOLD_LOAD;
            end else if (core_data == CMD_DOWN) begin
                up_d   = 1'b0;
                down_d = 1'b1;
                hold_d = HOLD_LOAD;
            end
        end
    end

    assign rx_data     = core_data;
    assign rx_valid    = core_vld;
    assign frame_err   = core_err;
    assign remote_up   = up_q;
    assign remote_down = down_q;

endmodule

// File: tb/tb_uart_rx_paddle.sv
// Directed bench for uart_rx_paddle with a 16-clock bit time and a 100-clock command hold.
module tb_uart_rx_paddle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       remote_up;
    logic       remote_down;

    int checks = 0;
    int passed = 0;

    int vld_cnt = 0;
    int err_cnt = 0;
    int up_cnt  = 0;
    int dn_cnt  = 0;
    int ovl_cnt = 0;

    uart_rx_paddle #(
        .CLK_FREQ    (160),
        .BAUD_RATE   (10),
        .HOLD_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RxD         (RxD),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .remote_up   (remote_up),
        .remote_down (remote_down)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)                vld_cnt <= vld_cnt + 1;
        if (frame_err)               err_cnt <= err_cnt + 1;
        if (remote_up)               up_cnt  <= up_cnt + 1;
        if (remote_down)             dn_cnt  <= dn_cnt + 1;
        if (remote_up && remote_down) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        RxD = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            idle(16);
        end
        RxD = stop_bit;
        idle(16);
        RxD = 1'b1;
    endtask

    task automatic test_reset;
        int v0, e0, u0, d0;
        rst = 1'b1;
        RxD = 1'b1;
        idle(5);
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
        checks++; if ({rx_valid, frame_err, remote_up, remote_down} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {rx_valid, frame_err, remote_up, remote_down}); else passed++;
        rst = 1'b0;
        v0 = vld_cnt; e0 = err_cnt; u0 = up_cnt; d0 = dn_cnt;
        idle(500);
        checks++; if (vld_cnt - v0 !== 0) $display("FAIL idle_valid: got %0d pulses want 0", vld_cnt - v0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL idle_err: got %0d pulses want 0", err_cnt - e0); else passed++;
        checks++; if ((up_cnt - u0) + (dn_cnt - d0) !== 0)
            $display("FAIL idle_remote: got %0d high cycles want 0", (up_cnt - u0) + (dn_cnt - d0)); else passed++;
    endtask

    task automatic test_cmd_up;
        int v0, e0, u0, d0;
        v0 = vld_cnt; e0 = err_cnt; u0 = up_cnt; d0 = dn_cnt;
        send_byte(8'h41, 1'b1);
        idle(1);
        checks++; if (vld_cnt - v0 !== 1) $display("FAIL up_valid: got %0d pulses want 1", vld_cnt - v0); else passed++;
        checks++; if (rx_data !== 8'h41) $display("FAIL up_data: got %h want 41", rx_data); else passed++;
        checks++; if (remote_up !== 1'b1) $display("FAIL up_level: got %b want 1", remote_up); else passed++;
        idle(150);
        checks++; if (up_cnt - u0 !== 100) $display("FAIL up_hold: got %0d cycles want 100", up_cnt - u0); else passed++;
        checks++; if (remote_up !== 1'b0) $display("FAIL up_expire: got %b want 0", remote_up); else passed++;
        checks++; if (dn_cnt - d0 !== 0) $display("FAIL up_no_down: got %0d cycles want 0", dn_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL up_no_err: got %0d pulses want 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_back_to_back;
        int v0, u0, d0, o0;
        v0 = vld_cnt; u0 = up_cnt; d0 = dn_cnt; o0 = ovl_cnt;
        send_byte(8'h42, 1'b1);
        checks++; if ({remote_up, remote_down} !== 2'b01)
            $display("FAIL b2b_first: got up/down %b want 01", {remote_up, remote_down}); else passed++;
        send_byte(8'h41, 1'b1);
        checks++; if ({remote_up, remote_down} !== 2'b10)
            $display("FAIL b2b_second: got up/down %b want 10", {remote_up, remote_down}); else passed++;
        checks++; if (rx_data !== 8'h41) $display("FAIL b2b_data: got %h want 41", rx_data); else passed++;
        idle(150);
        checks++; if (vld_cnt - v0 !== 2) $display("FAIL b2b_valid: got %0d pulses want 2", vld_cnt - v0); else passed++;
        checks++; if (dn_cnt - d0 !== 100) $display("FAIL b2b_down_hold: got %0d cycles want 100", dn_cnt - d0); else passed++;
        checks++; if (up_cnt - u0 !== 100) $display("FAIL b2b_up_hold: got %0d cycles want 100", up_cnt - u0); else passed++;
        checks++; if (ovl_cnt - o0 !== 0) $display("FAIL b2b_overlap: got %0d cycles want 0", ovl_cnt - o0); else passed++;
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = vld_cnt; e0 = err_cnt;
        RxD = 1'b0;
        idle(5);
        RxD = 1'b1;
        idle(30);
        checks++; if (vld_cnt - v0 !== 0) $display("FAIL glitch_valid: got %0d pulses want 0", vld_cnt - v0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL glitch_err: got %0d pulses want 0", err_cnt - e0); else passed++;
        send_byte(8'h42, 1'b1);
        idle(1);
        checks++; if (vld_cnt - v0 !== 1) $display("FAIL glitch_next_valid: got %0d pulses want 1", vld_cnt - v0); else passed++;
        checks++; if (rx_data !== 8'h42) $display("FAIL glitch_next_data: got %h want 42", rx_data); else passed++;
        checks++; if (remote_down !== 1'b1) $display("FAIL glitch_next_down: got %b want 1", remote_down); else passed++;
    endtask

    task automatic test_frame_err;
        int v0, e0, u0;
        v0 = vld_cnt; e0 = err_cnt; u0 = up_cnt;
        send_byte(8'h41, 1'b0);
        idle(20);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL ferr_pulse: got %0d pulses want 1", err_cnt - e0); else passed++;
        checks++; if (vld_cnt - v0 !== 0) $display("FAIL ferr_valid: got %0d pulses want 0", vld_cnt - v0); else passed++;
        checks++; if (rx_data !== 8'h42) $display("FAIL ferr_data: got %h want 42", rx_data); else passed++;
        checks++; if (up_cnt - u0 !== 0) $display("FAIL ferr_remote_up: got %0d cycles want 0", up_cnt - u0); else passed++;
        checks++; if (remote_down !== 1'b0) $display("FAIL ferr_remote_down: got %b want 0", remote_down); else passed++;
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        idle(1);
        checks++; if (vld_cnt - v0 !== 1) $display("FAIL x55_valid: got %0d pulses want 1", vld_cnt - v0); else passed++;
        checks++; if (rx_data !== 8'h55) $display("FAIL x55_data: got %h want 55", rx_data); else passed++;
        checks++; if ({remote_up, remote_down} !== 2'b00)
            $display("FAIL x55_remote: got up/down %b want 00", {remote_up, remote_down}); else passed++;
        checks++; if (up_cnt - u0 !== 0) $display("FAIL x55_no_up: got %0d cycles want 0", up_cnt - u0); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int v0, e0;
        d = 8'h41;
        v0 = vld_cnt; e0 = err_cnt;
        RxD = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            idle(16);
        end
        RxD = d[4];
        idle(8);
        rst = 1'b1;
        RxD = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(200);
        checks++; if (vld_cnt - v0 !== 0) $display("FAIL rstmid_valid: got %0d pulses want 0", vld_cnt - v0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL rstmid_err: got %0d pulses want 0", err_cnt - e0); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", rx_data); else passed++;
        checks++; if ({remote_up, remote_down} !== 2'b00)
            $display("FAIL rstmid_remote: got up/down %b want 00", {remote_up, remote_down}); else passed++;
        v0 = vld_cnt;
        send_byte(8'h42, 1'b1);
        idle(1);
        checks++; if (vld_cnt - v0 !== 1) $display("FAIL rstmid_next_valid: got %0d pulses want 1", vld_cnt - v0); else passed++;
        checks++; if (rx_data !== 8'h42) $display("FAIL rstmid_next_data: got %h want 42", rx_data); else passed++;
        checks++; if (remote_down !== 1'b1) $display("FAIL rstmid_next_down: got %b want 1", remote_down); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_cmd_up;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid_frame;
        idle(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
